// File: rtl/grid_scan_display.sv
// rtl/grid_scan_display.sv - double-buffered 8x8 row-scanned grid display driver
module grid_scan_display #(
    parameter int ROW_HOLD       = 1000,
    parameter bit ROW_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [63:0] frame_in,
    output logic        frame_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_BLANK
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);
    localparam logic [7:0]  ROW_OFF   = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

    state_t      state, state_n;
    logic [63:0] active, active_n;
    logic [63:0] pending, pending_n;
    logic        pending_full, pending_full_n;
    logic [2:0]  row, row_n;
    logic [15:0] cnt, cnt_n;
    logic        accept;

    logic [7:0]  row_sel_n;
    logic [7:0]  col_data_n;
    logic        frame_done_n;
    logic        frame_ready_n;

    always_comb begin
        state_n        = state;
        active_n       = active;
        pending_n      = pending;
        pending_full_n = pending_full;
        row_n          = row;
        cnt_n          = cnt;
        accept         = frame_valid & frame_ready;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    active_n = frame_in;
                    row_n    = 3'd0;
                    cnt_n    = 16'd0;
                    state_n  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = 16'd0;
                    state_n = ST_BLANK;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
                if (accept) begin
                    pending_n      = frame_in;
                    pending_full_n = 1'b1;
                end
            end
            ST_BLANK: begin
                row_n   = row + 3'd1;
                state_n = ST_SCAN;
                // Swap uses the registered flag; frame_ready is low whenever it is set,
                // so a same-edge accept can never collide with the swap.
                if (row == 3'd7 && pending_full) begin
                    active_n       = pending;
                    pending_full_n = 1'b0;
                end
                if (accept) begin
                    pending_n      = frame_in;
                    pending_full_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the state.
        if (state_n == ST_SCAN) begin
            row_sel_n  = (8'h01 << row_n) ^ ROW_OFF;
            col_data_n = active_n[{row_n, 3'b000} +: 8];
        end else begin
            row_sel_n  = ROW_OFF;
            col_data_n = 8'h00;
        end
        frame_done_n  = (state_n == ST_BLANK) && (row_n == 3'd7);
        frame_ready_n = (state_n == ST_IDLE) || !pending_full_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            active       <= 64'd0;
            pending      <= 64'd0;
            pending_full <= 1'b0;
            row          <= 3'd0;
            cnt          <= 16'd0;
            row_sel      <= ROW_OFF;
            col_data     <= 8'h00;
            frame_done   <= 1'b0;
            frame_ready  <= 1'b1;
        end else begin
            state        <= state_n;
            active       <= active_n;
            pending      <= pending_n;
            pending_full <= pending_full_n;
            row          <= row_n;
            cnt          <= cnt_n;
            row_sel      <= row_sel_n;
            col_data     <= col_data_n;
            frame_done   <= frame_done_n;
            frame_ready  <= frame_ready_n;
        end
    end

endmodule

// File: doc/grid_scan_display.md
GRID_SCAN_DISPLAY -- requirements
Module: grid_scan_display

Interface
REQ-001 Parameter ROW_HOLD, default 1000: clock cycles each row is driven; legal range 1..65535.
REQ-002 Parameter ROW_ACTIVE_LOW, default 0: when 1, row_sel is driven inverted; col_data is unaffected.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 frame_valid  input  1  producer has a 64-bit grid on frame_in.
REQ-006 frame_in  input  64  8x8 grid; cell (row r, col c) = bit 8r+c; 1 = alive/lit.
REQ-007 frame_ready  output  1  block can accept a frame this cycle.
REQ-008 row_sel  output  8  one-hot row drive; bit r = row r; all-zero while blanking.
REQ-009 col_data  output  8  column data for the driven row, equal to frame bits [8r+7:8r]; zero while blanking.
REQ-010 frame_done  output  1  one-cycle pulse marking the end of a full 8-row scan.

Function
REQ-011 Handshake: a frame is accepted on any edge where frame_valid=1 and frame_ready=1; frame_in is ignored otherwise.
REQ-012 Double buffer: the block holds an active register (currently scanned) plus a pending register with a pending_full flag.
REQ-013 frame_ready = ~pending_full in SCAN/BLANK; frame_ready = 1 in IDLE; it is a registered-state function with no combinational path from frame_valid.
REQ-014 States: IDLE, SCAN, BLANK.
REQ-015 IDLE: row_sel=0, col_data=0. On accept, frame_in loads directly into active, row=0, hold counter=0, next state SCAN.
REQ-016 SCAN: drives the row_sel one-hot for the current row and col_data = that row's byte of active. Hold counter increments each cycle; when it reaches ROW_HOLD-1, next state is BLANK and the counter clears.
REQ-017 BLANK: lasts exactly 1 cycle with row_sel=0 and col_data=0 (anti-ghosting). Row increments mod 8, then next state is SCAN.
REQ-018 Frame period = 8*(ROW_HOLD+1) cycles.
REQ-019 frame_done=1 only during the BLANK cycle that follows row 7.
REQ-020 Swap: in the BLANK cycle following row 7, if pending_full (registered value) = 1, then pending copies into active and pending_full clears at that edge. Otherwise active is rescanned unchanged.
REQ-021 Simultaneous accept and swap cannot occur, because frame_ready=0 while pending_full=1.
REQ-022 An accept during the post-row-7 BLANK cycle with pending empty loads pending only; it is displayed after the next frame_done.
REQ-023 Accept in SCAN/BLANK with pending empty sets pending_full at that edge. Active and the scan position are undisturbed.
REQ-024 The hold counter is 16 bits. Row is 3 bits and wraps 7->0. With ROW_HOLD=1, each row is driven for exactly 1 cycle.
REQ-025 Once a frame has been accepted, the block never returns to IDLE except via reset.
REQ-026 All outputs are registered; there are no combinational input-to-output paths.
REQ-027 When ROW_ACTIVE_LOW=1, row_sel = ~(one-hot), and the blank/IDLE value is 8'hFF.

Reset
REQ-028 reset=0 at an edge sets: state=IDLE, active=0, pending=0, pending_full=0, row=0, counter=0, row_sel=0 (8'hFF if ROW_ACTIVE_LOW), col_data=0, frame_done=0, frame_ready=1.
REQ-029 Reset asserted mid-scan or mid-handshake discards both buffers. A frame_valid presented during reset is not accepted.

Verification (ROW_HOLD=4, ROW_ACTIVE_LOW=0, accept edge = cycle 0)
REQ-030 First frame: frame_in=64'h8040201008040201 accepted in IDLE -> cycles 1-4 row_sel=8'h01, col_data=8'h01; cycle 5 row_sel=0; cycles 6-9 row_sel=8'h02, col_data=8'h02; ... row 7 gives col_data=8'h80.
REQ-031 End of frame: after the first frame -> frame_done=1 only at cycle 40; cycle 41 row_sel=8'h01 again (40-cycle period).
REQ-032 Double buffer: second frame 64'hFFFFFFFFFFFFFFFF accepted at cycle 10 -> frame_ready=0 from cycle 11; the display is unchanged through cycle 40; cycle 41 col_data=8'hFF; frame_ready=1 at cycle 41.
REQ-033 Backpressure: hold frame_valid=1 with a third frame while pending is full -> not accepted until frame_ready rises; accepted on the first edge with frame_ready=1; each frame is accepted exactly once.
REQ-034 Reset mid-scan: reset=0 at cycle 17 -> cycle 18 row_sel=0, col_data=0, frame_ready=1, state IDLE; no output activity until a new accept.
REQ-035 ROW_HOLD=1 corner: accept 64'h00000000000000AA -> rows alternate 1 drive cycle / 1 blank cycle; frame_done at cycle 16; row 0 col_data=8'hAA, other rows 0.
